// File: rtl/axis_stream_arbiter.sv
// Two-input AXI-Stream packet arbiter: round-robin at packet granularity onto one master port.
// Per-port packet counters and a sticky overrun flag for packets cut short at MAX_BEATS.
module axis_stream_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int MAX_BEATS = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    input  logic                     arb_enable,
    input  logic [DATA_SIZE-1:0]     s00_axis_tdata,
    input  logic [DATA_SIZE/8-1:0]   s00_axis_tstrb,
    input  logic                     s00_axis_tvalid,
    input  logic                     s00_axis_tlast,
    output logic                     s00_axis_tready,
    input  logic [DATA_SIZE-1:0]     s01_axis_tdata,
    input  logic [DATA_SIZE/8-1:0]   s01_axis_tstrb,
    input  logic                     s01_axis_tvalid,
    input  logic                     s01_axis_tlast,
    output logic                     s01_axis_tready,
    output logic [DATA_SIZE-1:0]     m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
    output logic                     m00_axis_tvalid,
    output logic                     m00_axis_tlast,
    input  logic                     m00_axis_tready,
    output logic [1:0]               grant,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     pkt_count0,
    output logic [CNT_WIDTH-1:0]     pkt_count1,
    output logic                     overrun
);

    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 last_grant, last_grant_nxt;
    logic [BW-1:0]        beat_cnt, beat_cnt_nxt;
    logic [CNT_WIDTH-1:0] pkt_count0_nxt, pkt_count1_nxt;
    logic                 overrun_nxt;
    logic                 sel, src_vld, src_last, eop;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            pkt_count0 <= '0;
            pkt_count1 <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            pkt_count0 <= pkt_count0_nxt;
            pkt_count1 <= pkt_count1_nxt;
            overrun    <= overrun_nxt;
        end
    end

    assign grant = {state == GRANT1, state == GRANT0};
    assign busy  = (state != IDLE);

    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        beat_cnt_nxt    = beat_cnt;
        pkt_count0_nxt  = pkt_count0;
        pkt_count1_nxt  = pkt_count1;
        overrun_nxt     = overrun;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        sel             = (state == GRANT1);
        src_vld         = 1'b0;
        src_last        = 1'b0;
        eop             = 1'b0;

        case (state)
            IDLE: begin
                // Tie-break toward the port that did not own the last packet.
                if (arb_enable && (s00_axis_tvalid || s01_axis_tvalid)) begin
                    if (s00_axis_tvalid && s01_axis_tvalid)
                        state_nxt = last_grant ? GRANT0 : GRANT1;
                    else
                        state_nxt = s00_axis_tvalid ? GRANT0 : GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                src_vld         = sel ? s01_axis_tvalid : s00_axis_tvalid;
                src_last        = sel ? s01_axis_tlast  : s00_axis_tlast;
                eop             = src_last || (beat_cnt == LAST_BEAT);
                m00_axis_tdata  = sel ? s01_axis_tdata : s00_axis_tdata;
                m00_axis_tstrb  = sel ? s01_axis_tstrb : s00_axis_tstrb;
                m00_axis_tvalid = src_vld;
                m00_axis_tlast  = eop;
                s00_axis_tready = !sel && m00_axis_tready;
                s01_axis_tready = sel && m00_axis_tready;
                if (src_vld && m00_axis_tready) begin
                    if (eop) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = sel;
                        beat_cnt_nxt   = '0;
                        if (sel) pkt_count1_nxt = pkt_count1 + CNT_WIDTH'(1);
                        else     pkt_count0_nxt = pkt_count0 + CNT_WIDTH'(1);
                        // A cut made by the beat limit rather than the source is sticky.
                        if (!src_last) overrun_nxt = 1'b1;
                    end else begin
                        beat_cnt_nxt = beat_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Bench for axis_stream_arbiter: vector table, directed corner sequences, random vs packet-level model.
module tb_axis_stream_arbiter;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MB = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en;
    logic [DW-1:0] d0, d1;
    logic [SW-1:0] st0, st1;
    logic          v0, l0, v1, l1, rdy;
    logic          r0, r1;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic          m_vld, m_last;
    logic [1:0]    grant;
    logic          busy, ovr;
    logic [CW-1:0] c0, c1;

    always #5 clk = ~clk;

    axis_stream_arbiter #(.DATA_SIZE(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n), .arb_enable(en),
        .s00_axis_tdata(d0), .s00_axis_tstrb(st0), .s00_axis_tvalid(v0),
        .s00_axis_tlast(l0), .s00_axis_tready(r0),
        .s01_axis_tdata(d1), .s01_axis_tstrb(st1), .s01_axis_tvalid(v1),
        .s01_axis_tlast(l1), .s01_axis_tready(r1),
        .m00_axis_tdata(m_data), .m00_axis_tstrb(m_strb), .m00_axis_tvalid(m_vld),
        .m00_axis_tlast(m_last), .m00_axis_tready(rdy),
        .grant(grant), .busy(busy), .pkt_count0(c0), .pkt_count1(c1), .overrun(ovr)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle before the next rising edge.
    task automatic drive(input logic e, input logic a_v, input logic a_l, input logic [DW-1:0] a_d,
                         input logic b_v, input logic b_l, input logic [DW-1:0] b_d, input logic r,
                         input logic [SW-1:0] a_s = 4'hf, input logic [SW-1:0] b_s = 4'h3);
        @(negedge clk);
        en = e; v0 = a_v; l0 = a_l; d0 = a_d; st0 = a_s;
        v1 = b_v; l1 = b_l; d1 = b_d; st1 = b_s; rdy = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 0; v0 = 0; l0 = 0; d0 = '0; v1 = 0; l1 = 0; d1 = '0; rdy = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          rst;
        logic          en, v0, l0;
        logic [DW-1:0] d0;
        logic          v1, l1;
        logic [DW-1:0] d1;
        logic          rdy;
        logic [1:0]    g;
        logic          vld;
        logic [DW-1:0] data;
        logic          last, r0, r1;
        int            c0, c1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rs, logic e, logic a_v, logic a_l, logic [DW-1:0] a_d,
                                logic b_v, logic b_l, logic [DW-1:0] b_d, logic r,
                                logic [1:0] g, logic vld, logic [DW-1:0] data, logic last,
                                logic e0, logic e1, int k0, int k1);
        vec_t t;
        t.rst = rs; t.en = e; t.v0 = a_v; t.l0 = a_l; t.d0 = a_d;
        t.v1 = b_v; t.l1 = b_l; t.d1 = b_d; t.rdy = r;
        t.g = g; t.vld = vld; t.data = data; t.last = last; t.r0 = e0; t.r1 = e1;
        t.c0 = k0; t.c1 = k1;
        return t;
    endfunction

    // Random-phase reference: whole-packet view (owner, beats sent, last winner, counts).
    int own, nb, lg;
    int mc[2];
    bit mo;

    initial begin
        en = 0; v0 = 0; l0 = 0; d0 = '0; st0 = '0; v1 = 0; l1 = 0; d1 = '0; st1 = '0; rdy = 0;

        // single 4-beat packet from port 0
        tv.push_back(mk(0, 1, 1,0,'h10, 0,0,0, 1, 2'b00, 0,   0,    0, 0,0, 0,0));
        tv.push_back(mk(0, 1, 1,0,'h10, 0,0,0, 1, 2'b01, 1, 'h10,   0, 1,0, 0,0));
        tv.push_back(mk(0, 1, 1,0,'h11, 0,0,0, 1, 2'b01, 1, 'h11,   0, 1,0, 0,0));
        tv.push_back(mk(0, 1, 1,0,'h12, 0,0,0, 1, 2'b01, 1, 'h12,   0, 1,0, 0,0));
        tv.push_back(mk(0, 1, 1,1,'h13, 0,0,0, 1, 2'b01, 1, 'h13,   1, 1,0, 0,0));
        tv.push_back(mk(0, 1, 0,0,0,    0,0,0, 1, 2'b00, 0,   0,    0, 0,0, 1,0));
        // both ports busy, 2-beat packets, alternating from port 0 after reset
        tv.push_back(mk(1, 1, 1,0,'h20, 1,0,'h30, 1, 2'b00, 0, 0,    0, 0,0, 0,0));
        tv.push_back(mk(0, 1, 1,0,'h20, 1,0,'h30, 1, 2'b01, 1, 'h20, 0, 1,0, 0,0));
        tv.push_back(mk(0, 1, 1,1,'h21, 1,0,'h30, 1, 2'b01, 1, 'h21, 1, 1,0, 0,0));
        tv.push_back(mk(0, 1, 1,0,'h22, 1,0,'h30, 1, 2'b00, 0, 0,    0, 0,0, 1,0));
        tv.push_back(mk(0, 1, 1,0,'h22, 1,0,'h30, 1, 2'b10, 1, 'h30, 0, 0,1, 1,0));
        tv.push_back(mk(0, 1, 1,0,'h22, 1,1,'h31, 1, 2'b10, 1, 'h31, 1, 0,1, 1,0));
        tv.push_back(mk(0, 1, 1,0,'h22, 1,0,'h32, 1, 2'b00, 0, 0,    0, 0,0, 1,1));
        tv.push_back(mk(0, 1, 1,0,'h22, 1,0,'h32, 1, 2'b01, 1, 'h22, 0, 1,0, 1,1));
        tv.push_back(mk(0, 1, 1,1,'h23, 1,0,'h32, 1, 2'b01, 1, 'h23, 1, 1,0, 1,1));
        tv.push_back(mk(0, 1, 1,0,'h24, 1,0,'h32, 1, 2'b00, 0, 0,    0, 0,0, 2,1));
        tv.push_back(mk(0, 1, 1,0,'h24, 1,0,'h32, 1, 2'b10, 1, 'h32, 0, 0,1, 2,1));
        tv.push_back(mk(0, 1, 1,0,'h24, 1,1,'h33, 1, 2'b10, 1, 'h33, 1, 0,1, 2,1));
        tv.push_back(mk(0, 1, 0,0,0,    0,0,0,    1, 2'b00, 0, 0,    0, 0,0, 2,2));
        // port 1 under downstream backpressure 1,0,0,1; port 0 valid but never readied
        tv.push_back(mk(0, 1, 0,0,0,    1,0,'h40, 1, 2'b00, 0, 0,    0, 0,0, 2,2));
        tv.push_back(mk(0, 1, 1,0,'h99, 1,0,'h40, 1, 2'b10, 1, 'h40, 0, 0,1, 2,2));
        tv.push_back(mk(0, 1, 1,0,'h99, 1,0,'h41, 0, 2'b10, 1, 'h41, 0, 0,0, 2,2));
        tv.push_back(mk(0, 1, 1,0,'h99, 1,0,'h41, 0, 2'b10, 1, 'h41, 0, 0,0, 2,2));
        tv.push_back(mk(0, 1, 1,0,'h99, 1,1,'h41, 1, 2'b10, 1, 'h41, 1, 0,1, 2,2));
        tv.push_back(mk(0, 1, 0,0,0,    0,0,0,    1, 2'b00, 0, 0,    0, 0,0, 2,3));

        // reset state, sampled while reset is held
        #2;
        chk("rst grant", grant, 2'b00);
        chk("rst busy", busy, 0);
        chk("rst m_vld", m_vld, 0);
        chk("rst m_data", m_data, 0);
        chk("rst m_last", m_last, 0);
        chk("rst r0", r0, 0);
        chk("rst r1", r1, 0);
        chk("rst c0", c0, 0);
        chk("rst c1", c1, 0);
        chk("rst ovr", ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            drive(tv[i].en, tv[i].v0, tv[i].l0, tv[i].d0, tv[i].v1, tv[i].l1, tv[i].d1, tv[i].rdy);
            chk($sformatf("vec%0d grant", i), grant, tv[i].g);
            chk($sformatf("vec%0d busy", i), busy, tv[i].g != 2'b00);
            chk($sformatf("vec%0d m_vld", i), m_vld, tv[i].vld);
            chk($sformatf("vec%0d m_data", i), m_data, tv[i].data);
            chk($sformatf("vec%0d m_last", i), m_last, tv[i].last);
            chk($sformatf("vec%0d r0", i), r0, tv[i].r0);
            chk($sformatf("vec%0d r1", i), r1, tv[i].r1);
            chk($sformatf("vec%0d c0", i), c0, tv[i].c0);
            chk($sformatf("vec%0d c1", i), c1, tv[i].c1);
        end

        // runaway packet: 10 beats without tlast, cut at MB
        do_reset();
        drive(1, 1,0,'h50, 0,0,0, 1);
        chk("ovf idle grant", grant, 2'b00);
        for (int i = 0; i < MB; i++) begin
            drive(1, 1,0,'h50 + i, 0,0,0, 1);
            chk($sformatf("ovf beat%0d data", i), m_data, 'h50 + i);
            chk($sformatf("ovf beat%0d last", i), m_last, i == MB - 1);
        end
        drive(1, 1,0,'h58, 0,0,0, 1);
        chk("ovf gap grant", grant, 2'b00);
        chk("ovf flag", ovr, 1);
        chk("ovf c0", c0, 1);
        drive(1, 1,0,'h58, 0,0,0, 1);
        chk("ovf tail0 grant", grant, 2'b01);
        chk("ovf tail0 data", m_data, 'h58);
        chk("ovf tail0 last", m_last, 0);
        drive(1, 1,1,'h59, 0,0,0, 1);
        chk("ovf tail1 data", m_data, 'h59);
        chk("ovf tail1 last", m_last, 1);
        drive(1, 0,0,0, 0,0,0, 1);
        chk("ovf end c0", c0, 2);
        chk("ovf sticky", ovr, 1);

        // asynchronous reset in the middle of a packet
        drive(1, 1,0,'h60, 0,0,0, 1);
        drive(1, 1,0,'h60, 0,0,0, 1);
        chk("mid vld pre", m_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst vld", m_vld, 0);
        chk("mid rst grant", grant, 2'b00);
        chk("mid rst busy", busy, 0);
        chk("mid rst r0", r0, 0);
        chk("mid rst c0", c0, 0);
        chk("mid rst ovr", ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // arb_enable dropped on beat 2 of a 5-beat packet
        do_reset();
        drive(1, 1,0,'h70, 1,0,'h80, 1);
        chk("en idle grant", grant, 2'b00);
        for (int i = 0; i < 5; i++) begin
            drive(i < 1, 1, i == 4, 'h70 + i, 1,0,'h80, 1);
            chk($sformatf("en beat%0d grant", i), grant, 2'b01);
            chk($sformatf("en beat%0d data", i), m_data, 'h70 + i);
            chk($sformatf("en beat%0d last", i), m_last, i == 4);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0,0,0, 1,0,'h80, 1);
            chk($sformatf("en hold%0d grant", k), grant, 2'b00);
        end
        drive(1, 0,0,0, 1,0,'h80, 1);
        chk("en re idle", grant, 2'b00);
        drive(1, 0,0,0, 1,0,'h80, 1);
        chk("en re grant", grant, 2'b10);
        chk("en re data", m_data, 'h80);

        // random traffic against the packet-level model
        do_reset();
        own = -1; nb = 0; lg = 1; mc[0] = 0; mc[1] = 0; mo = 0;
        for (int n = 0; n < 3000; n++) begin
            logic          ee, rr;
            logic          vv[2], ll[2];
            logic [DW-1:0] dd[2];
            logic [SW-1:0] ss[2];
            logic          xl;
            ee = ($urandom_range(0, 9) != 0);
            rr = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 2; p++) begin
                vv[p] = ($urandom_range(0, 3) != 0);
                ll[p] = ($urandom_range(0, 5) == 0);
                dd[p] = $urandom;
                ss[p] = SW'($urandom);
            end
            drive(ee, vv[0], ll[0], dd[0], vv[1], ll[1], dd[1], rr, ss[0], ss[1]);
            xl = (own >= 0) && (ll[own] || nb == MB - 1);
            chk("rnd grant", grant, own < 0 ? 2'b00 : (own == 0 ? 2'b01 : 2'b10));
            chk("rnd busy", busy, own >= 0);
            chk("rnd m_vld", m_vld, own >= 0 ? vv[own] : 1'b0);
            chk("rnd m_data", m_data, own >= 0 ? dd[own] : '0);
            chk("rnd m_strb", m_strb, own >= 0 ? ss[own] : '0);
            chk("rnd m_last", m_last, xl);
            chk("rnd r0", r0, own == 0 && rr);
            chk("rnd r1", r1, own == 1 && rr);
            chk("rnd c0", c0, mc[0]);
            chk("rnd c1", c1, mc[1]);
            chk("rnd ovr", ovr, mo);
            if (own < 0) begin
                if (ee && (vv[0] || vv[1])) begin
                    own = (vv[0] && vv[1]) ? 1 - lg : (vv[0] ? 0 : 1);
                    nb = 0;
                end
            end else if (vv[own] && rr) begin
                if (xl) begin
                    mc[own] = (mc[own] + 1) % (1 << CW);
                    if (!ll[own]) mo = 1;
                    lg = own;
                    own = -1;
                    nb = 0;
                end else begin
                    nb++;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
